// File: rtl/cnn_layer_accel_rd_arb.sv
// cnn_layer_accel_rd_arb: round-robin arbiter sharing one memory read port among C_NUM_REQ requesters
module cnn_layer_accel_rd_arb #(
    parameter int C_NUM_REQ  = 4,
    parameter int C_ADDR_WTH = 32,
    parameter int C_LEN_WTH  = 16,
    parameter int C_DATA_WTH = 128
) (
    input  logic                            clk_intf,
    input  logic                            rst,
    input  logic [C_NUM_REQ-1:0]            rd_req,
    input  logic [C_NUM_REQ*C_ADDR_WTH-1:0] rd_addr,
    input  logic [C_NUM_REQ*C_LEN_WTH-1:0]  rd_len,
    output logic [C_NUM_REQ-1:0]            rd_req_ack,
    output logic [C_NUM_REQ-1:0]            rd_in_prog,
    output logic [C_DATA_WTH-1:0]           rd_data,
    output logic [C_NUM_REQ-1:0]            rd_data_vld,
    input  logic [C_NUM_REQ-1:0]            rd_data_rdy,
    output logic [C_NUM_REQ-1:0]            rd_cmpl,
    output logic                            mem_req,
    output logic [C_ADDR_WTH-1:0]           mem_addr,
    output logic [C_LEN_WTH-1:0]            mem_len,
    input  logic                            mem_req_ack,
    input  logic [C_DATA_WTH-1:0]           mem_data,
    input  logic                            mem_data_vld,
    output logic                            mem_data_rdy
);
    localparam int IW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, CMPL} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           grant_q, grant_d, last_q, last_d, rr_idx, rr_cand;
    logic                    rr_hit, xfer, beat;
    logic [C_ADDR_WTH-1:0]   addr_q, addr_d;
    logic [C_LEN_WTH-1:0]    len_q, len_d, cnt_q, cnt_d;
    logic [C_NUM_REQ-1:0]    gnt_oh;

    assign xfer = (state_q == XFER);
    assign beat = xfer && mem_data_vld && mem_data_rdy;

    // round-robin search starting just after the last completed grant
    always_comb begin
        rr_idx  = '0;
        rr_hit  = 1'b0;
        rr_cand = '0;
        for (int i = 1; i <= C_NUM_REQ; i++) begin
            rr_cand = IW'((int'(last_q) + i) % C_NUM_REQ);
            if (!rr_hit && rd_req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    // one-hot view of the current owner
    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < C_NUM_REQ; i++) gnt_oh[i] = (grant_q == IW'(i));
    end

    // transaction sequencing: grant, issue, beat counting, completion
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (rr_hit) begin
                grant_d = rr_idx;
                addr_d  = rd_addr[int'(rr_idx)*C_ADDR_WTH +: C_ADDR_WTH];
                len_d   = rd_len[int'(rr_idx)*C_LEN_WTH +: C_LEN_WTH];
                state_d = ISSUE;
            end
            ISSUE: if (mem_req_ack) begin
                cnt_d   = len_q;
                state_d = (len_q != '0) ? XFER : CMPL;
            end
            XFER: if (beat) begin
                cnt_d   = cnt_q - C_LEN_WTH'(1);
                state_d = (cnt_q == C_LEN_WTH'(1)) ? CMPL : XFER;
            end
            default: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
        endcase
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk_intf or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(C_NUM_REQ - 1);
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req      = (state_q == ISSUE);
    assign mem_addr     = addr_q;
    assign mem_len      = len_q;
    assign rd_req_ack   = (mem_req && mem_req_ack) ? gnt_oh : '0;
    assign rd_in_prog   = (state_q != IDLE) ? gnt_oh : '0;
    assign rd_cmpl      = (state_q == CMPL) ? gnt_oh : '0;
    assign rd_data_vld  = (xfer && mem_data_vld) ? gnt_oh : '0;
    assign mem_data_rdy = xfer && rd_data_rdy[grant_q];
    assign rd_data      = xfer ? mem_data : '0;
endmodule
